vram_fill_arb: RTL and testbench
================================

VRAM_FILL_ARB -- requirements
Module: vram_fill_arb

Interface
REQ-001 SHALL provide parameter SCREEN_W, default 320, meaning pixels per row.
REQ-002 SHALL provide parameter SCREEN_H, default 240, meaning rows per frame.
REQ-003 SHALL have clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have start  input  1  one-cycle fill request.
REQ-006 SHALL have x0, y0  input  9, 8  rectangle top-left pixel.
REQ-007 SHALL have w, h  input  9, 8  rectangle width and height in pixels.
REQ-008 SHALL have color  input  16  fill pixel value.
REQ-009 SHALL have busy and done  output  1 each  fill in progress; one-cycle completion pulse.
REQ-010 SHALL have cpu_req, cpu_we  input  1 each  CPU access request and write select.
REQ-011 SHALL have cpu_addr, cpu_wdata  input  17, 16  CPU word address and write data.
REQ-012 SHALL have cpu_ack, cpu_rdata  output  1, 16  access complete; read data valid with ack.
REQ-013 SHALL have vram_enable, vram_we, vram_address, vram_wdata  output  1, 1, 17, 16  to VRAM port 1.
REQ-014 SHALL have vram_rdata  input  16  VRAM port 1 read data, valid one cycle after an enabled access.

Function
REQ-015 SHALL implement FSM states IDLE, FILL, DONE.
REQ-016 In IDLE, start SHALL latch x0, y0, w, h, and color. It SHALL enter FILL, or DONE if the effective w or h is 0.
REQ-017 start while busy SHALL be ignored; latched parameters SHALL NOT change.
REQ-018 The start address SHALL be y0*SCREEN_W+x0. Row base SHALL advance by SCREEN_W per row, using shifts and adds only, with no multiplier.
REQ-019 Fill order SHALL be row-major: column counter 0..w-1, then the next row, with the last pixel at row h-1, column w-1.
REQ-020 Each granted fill cycle SHALL drive vram_enable=1, vram_we=1, vram_address=current pixel, and vram_wdata=color, then advance one pixel.
REQ-021 After the last pixel is written, the block SHALL enter DONE. done SHALL be high for exactly that one cycle, then the block SHALL return to IDLE.
REQ-022 busy SHALL be high in FILL and DONE, and low in IDLE.
REQ-023 Arbitration: in any cycle with no cpu_ack high, a pending cpu_req SHALL win over the fill engine. The exception is the cycle immediately after a CPU grant: if a fill is pending, the fill engine SHALL win. This alternates under contention, and neither side SHALL starve.
REQ-024 A CPU grant in cycle N SHALL drive vram_* combinationally from cpu_we, cpu_addr, and cpu_wdata. cpu_ack SHALL be high in cycle N+1, with cpu_rdata equal to vram_rdata.
REQ-025 cpu_req SHALL be sampled only while cpu_ack is low. A single held request SHALL yield exactly one access.
REQ-026 With no grant, vram_enable and vram_we SHALL be 0. The vram_address and vram_wdata values are don't-care.
REQ-027 Address arithmetic SHALL be 17 bits, and any overflow SHALL truncate modulo 2^17.

Reset
REQ-028 Reset SHALL force IDLE with busy=0, done=0, cpu_ack=0, vram_enable=0, vram_we=0, and counters at 0.
REQ-029 Reset mid-fill SHALL stop writes from the next cycle. done SHALL NOT pulse, and the partial fill SHALL remain in VRAM.
REQ-030 Reset in an ack-pending cycle SHALL drop cpu_ack, and the CPU SHALL re-issue the request.

Configuration
REQ-031 Macro FILL_CLIP_EN SHALL select clipping of the fill rectangle to the screen.
REQ-032 With FILL_CLIP_EN defined, effective w SHALL be min(w, SCREEN_W-x0) and effective h SHALL be min(h, SCREEN_H-y0). If x0>=SCREEN_W or y0>=SCREEN_H, the block SHALL go to DONE with zero writes.
REQ-033 Without FILL_CLIP_EN, w and h SHALL be used unmodified. Pixels past a row end SHALL spill linearly into the next row's addresses.

Verification
REQ-034 Scenario: start x0=10 y0=2 w=3 h=2 color=16'hF800, no CPU activity -> writes to 650,651,652,970,971,972 on consecutive cycles, then a done pulse; 6 writes plus 1 done cycle total.
REQ-035 Scenario: start with w=0 h=5 -> busy for 1 cycle, done pulse, zero vram_we cycles.
REQ-036 Scenario: cpu_req held continuously during the REQ-034 fill -> CPU and fill accesses alternate, the fill completes after 6 fill grants, and each CPU read returns the VRAM word at cpu_addr with ack one cycle after its grant.
REQ-037 Scenario: CPU write addr 100 data 16'h1234, then read addr 100 -> the read ack carries cpu_rdata=16'h1234.
REQ-038 Scenario with FILL_CLIP_EN: x0=318 y0=239 w=5 h=4 -> exactly 2 writes at 76798 and 76799. Without the macro, the same stimulus gives 20 writes starting at 76798, with addresses truncated to 17 bits.
REQ-039 Scenario: reset asserted after the 3rd write of the REQ-034 fill -> no further vram_we, no done, busy=0 the cycle after reset.

Source files
------------

// File: rtl/vram_fill_arb.sv
// Rectangle fill engine sharing one VRAM port with a CPU; CPU wins except right after its own grant.
// Optional macro FILL_CLIP_EN clips the rectangle to the screen; otherwise rows spill linearly.
module vram_fill_arb #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [8:0]  x0,
    input  logic [7:0]  y0,
    input  logic [8:0]  w,
    input  logic [7:0]  h,
    input  logic [15:0] color,
    output logic        busy,
    output logic        done,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [16:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,
    output logic        vram_enable,
    output logic        vram_we,
    output logic [16:0] vram_address,
    output logic [15:0] vram_wdata,
    input  logic [15:0] vram_rdata
);

    localparam int unsigned XW = 9;
    localparam int unsigned YW = 8;
    localparam int unsigned AW = 17;
    localparam int unsigned DW = 16;
    localparam logic [AW-1:0] ROW_STRIDE = AW'(SCREEN_W);

    // The frame must fit in the 17-bit word address space.
    if (SCREEN_W * SCREEN_H > (1 << AW)) begin : g_bad_size
        $error("vram_fill_arb: SCREEN_W*SCREEN_H exceeds the VRAM address space");
    end

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    state_t        state, state_d;
    logic [XW-1:0] w_l, w_d, col, col_d;
    logic [YW-1:0] h_l, h_d, row, row_d;
    logic [AW-1:0] row_base, row_base_d;
    logic [DW-1:0] color_l, color_d;
    logic [XW-1:0] eff_w;
    logic [YW-1:0] eff_h;
    logic [AW-1:0] y_scaled, start_addr, pix_addr;
    logic          cpu_grant, fill_grant;

    // y0*SCREEN_W built from shifted copies of y0, one per set bit of the stride
    always_comb begin
        y_scaled = '0;
        for (int unsigned i = 0; i < AW; i++) begin
            if (ROW_STRIDE[i]) begin
                y_scaled = y_scaled + (AW'(y0) << i);
            end
        end
        start_addr = y_scaled + AW'(x0);
    end

`ifdef FILL_CLIP_EN
    localparam logic [XW:0] W_LIM = (XW+1)'(SCREEN_W);
    localparam logic [YW:0] H_LIM = (YW+1)'(SCREEN_H);
    logic [XW:0] room_w;
    logic [YW:0] room_h;

    always_comb begin
        room_w = W_LIM - {1'b0, x0};
        room_h = H_LIM - {1'b0, y0};
        if (({1'b0, x0} >= W_LIM) || ({1'b0, y0} >= H_LIM)) begin
            eff_w = '0;
            eff_h = '0;
        end else begin
            eff_w = ({1'b0, w} > room_w) ? XW'(room_w) : w;
            eff_h = ({1'b0, h} > room_h) ? YW'(room_h) : h;
        end
    end
`else
    assign eff_w = w;
    assign eff_h = h;
`endif

    assign pix_addr = row_base + AW'(col);

    // Next state, arbitration and pixel walk
    always_comb begin
        state_d    = state;
        w_d        = w_l;
        h_d        = h_l;
        color_d    = color_l;
        col_d      = col;
        row_d      = row;
        row_base_d = row_base;
        cpu_grant  = cpu_req && !cpu_ack;
        fill_grant = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    w_d        = eff_w;
                    h_d        = eff_h;
                    color_d    = color;
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = start_addr;
                    state_d    = ((eff_w == '0) || (eff_h == '0)) ? DONE : FILL;
                end
            end
            FILL: begin
                fill_grant = !cpu_grant;
                if (fill_grant) begin
                    if (col == w_l - XW'(1)) begin
                        col_d      = '0;
                        row_d      = row + YW'(1);
                        row_base_d = row_base + ROW_STRIDE;
                        if (row == h_l - YW'(1)) begin
                            state_d = DONE;
                        end
                    end else begin
                        col_d = col + XW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cpu_ack  <= 1'b0;
            w_l      <= '0;
            h_l      <= '0;
            color_l  <= '0;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
        end else begin
            state    <= state_d;
            cpu_ack  <= cpu_grant;
            w_l      <= w_d;
            h_l      <= h_d;
            color_l  <= color_d;
            col      <= col_d;
            row      <= row_d;
            row_base <= row_base_d;
        end
    end

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign cpu_rdata    = vram_rdata;
    assign vram_enable  = cpu_grant || fill_grant;
    assign vram_we      = cpu_grant ? cpu_we : fill_grant;
    assign vram_address = cpu_grant ? cpu_addr : pix_addr;
    assign vram_wdata   = cpu_grant ? cpu_wdata : color_l;

endmodule

// File: tb/tb_vram_fill_arb.sv
// Self-checking bench for vram_fill_arb: VRAM model, write monitor and a pixel-list reference model.
module tb_vram_fill_arb;

    localparam int SW   = 320;
    localparam int SH   = 240;
    localparam int AMOD = 131072;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [8:0]  x0, w;
    logic [7:0]  y0, h;
    logic [15:0] color;
    logic        busy, done;
    logic        cpu_req, cpu_we;
    logic [16:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        vram_enable, vram_we;
    logic [16:0] vram_address;
    logic [15:0] vram_wdata;
    logic [15:0] vram_rdata;

    int checks = 0;
    int errors = 0;

    vram_fill_arb #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x0(x0), .y0(y0), .w(w), .h(h), .color(color),
        .busy(busy), .done(done),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .vram_enable(vram_enable), .vram_we(vram_we), .vram_address(vram_address),
        .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
    );

    always #5 clk = ~clk;

    // VRAM port model: one-cycle read latency
    logic [15:0] mem [0:AMOD-1];
    always @(posedge clk) begin
        if (vram_enable) begin
            if (vram_we) mem[vram_address] <= vram_wdata;
            vram_rdata <= mem[vram_address];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor, sampled mid-cycle
    int          wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          done_q[$];
    int          busy_cnt = 0;
    always @(negedge clk) begin
        if (vram_enable && vram_we) begin
            wr_addr_q.push_back(int'(vram_address));
            wr_data_q.push_back(vram_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (done) done_q.push_back(cyc);
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    int exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: list of pixel addresses the fill must write, in order
    task automatic build_exp(input int xv, input int yv, input int wv, input int hv);
        int ew, eh;
        exp_q.delete();
        ew = wv;
        eh = hv;
`ifdef FILL_CLIP_EN
        if (xv >= SW || yv >= SH) begin
            ew = 0;
            eh = 0;
        end else begin
            if (ew > SW - xv) ew = SW - xv;
            if (eh > SH - yv) eh = SH - yv;
        end
`endif
        for (int r = 0; r < eh; r++)
            for (int c = 0; c < ew; c++)
                exp_q.push_back(((yv * SW) + xv + r * SW + c) % AMOD);
    endtask

    task automatic run_fill(input int xv, input int yv, input int wv, input int hv,
                            input logic [15:0] cv, input bit poke);
        int base, dbase, bbase, t0, n, to;
        build_exp(xv, yv, wv, hv);
        base  = wr_addr_q.size();
        dbase = done_q.size();
        bbase = busy_cnt;
        x0 = 9'(xv); y0 = 8'(yv); w = 9'(wv); h = 8'(hv); color = cv;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        if (poke) begin
            x0 = 9'($urandom_range(0, 300)); y0 = 8'($urandom_range(0, 200));
            w = 9'($urandom_range(1, 9)); h = 8'($urandom_range(1, 9));
            color = ~cv;
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        to = 0;
        while (done_q.size() == dbase && to < 400) begin
            tick();
            to++;
        end
        checks++;
        if (done_q.size() == dbase) begin
            errors++;
            $display("FAIL fill_done_timeout: no done after %0d cycles", to);
        end
        n = wr_addr_q.size() - base;
        checks++;
        if (n !== exp_q.size()) begin
            errors++;
            $display("FAIL fill_count: got %0d writes expected %0d", n, exp_q.size());
        end
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            checks++;
            if (wr_addr_q[base+i] !== exp_q[i] || wr_data_q[base+i] !== cv ||
                wr_cyc_q[base+i] !== t0 + 1 + i) begin
                errors++;
                $display("FAIL fill_pixel[%0d]: got addr %0d data %h cyc %0d expected addr %0d data %h cyc %0d",
                         i, wr_addr_q[base+i], wr_data_q[base+i], wr_cyc_q[base+i] - t0,
                         exp_q[i], cv, 1 + i);
            end
        end
        if (done_q.size() > dbase) begin
            checks++;
            if (done_q[dbase] !== t0 + 1 + exp_q.size() || done_q.size() !== dbase + 1) begin
                errors++;
                $display("FAIL fill_done_time: got cyc %0d (pulses %0d) expected cyc %0d (pulses 1)",
                         done_q[dbase] - t0, done_q.size() - dbase, 1 + exp_q.size());
            end
        end
        checks++;
        if (busy_cnt - bbase !== exp_q.size() + 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_busy: got %0d busy cycles (busy now %b) expected %0d (busy now 0)",
                     busy_cnt - bbase, busy, exp_q.size() + 1);
        end
    endtask

    task automatic cpu_access(input bit we, input int a, input logic [15:0] d,
                              output logic [15:0] rd, output int lat);
        int t0;
        tick();
        cpu_req = 1'b1; cpu_we = we; cpu_addr = 17'(a); cpu_wdata = d;
        t0 = cyc;
        lat = -1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (cpu_ack) begin
                lat = cyc - t0;
                break;
            end
        end
        rd = cpu_rdata;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, done, cpu_ack, vram_enable, vram_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got busy/done/ack/en/we %b expected 00000",
                     {busy, done, cpu_ack, vram_enable, vram_we});
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({busy, vram_enable} !== 2'b0) begin
            errors++;
            $display("FAIL idle_outputs: got busy/en %b expected 00", {busy, vram_enable});
        end
    endtask

    task automatic test_basic_fill();
        run_fill(10, 2, 3, 2, 16'hF800, 1'b0);
        checks++;
        if (exp_q.size() !== 6 || exp_q[0] !== 650 || exp_q[5] !== 972) begin
            errors++;
            $display("FAIL basic_model: got %0d pixels expected 6 at 650..972", exp_q.size());
        end
    endtask

    task automatic test_zero_size();
        run_fill(10, 2, 0, 5, 16'h0F0F, 1'b0);
        run_fill(10, 2, 4, 0, 16'h0F0F, 1'b0);
    endtask

    task automatic test_cpu_rw();
        logic [15:0] rd, d;
        int lat, a;
        cpu_access(1'b1, 100, 16'h1234, rd, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL cpu_write_lat: got %0d expected 1", lat);
        end
        cpu_access(1'b0, 100, 16'h0, rd, lat);
        checks++;
        if (lat !== 1 || rd !== 16'h1234) begin
            errors++;
            $display("FAIL cpu_read_100: got lat %0d data %h expected lat 1 data 1234", lat, rd);
        end
        for (int i = 0; i < 4; i++) begin
            a = int'($urandom_range(200, 60000));
            d = 16'($urandom);
            cpu_access(1'b1, a, d, rd, lat);
            cpu_access(1'b0, a, 16'h0, rd, lat);
            checks++;
            if (lat !== 1 || rd !== d) begin
                errors++;
                $display("FAIL cpu_rand_rw[%0d]: got lat %0d data %h expected lat 1 data %h", i, lat, rd, d);
            end
        end
    endtask

    task automatic test_contention();
        logic [15:0] pre[16];
        logic [15:0] rd, expd;
        int lat, base, dbase, t0, k, to, acks, n;
        bit fin;
        for (int i = 0; i < 16; i++) begin
            pre[i] = 16'($urandom);
            cpu_access(1'b1, 5000 + i, pre[i], rd, lat);
        end
        build_exp(10, 2, 3, 2);
        base  = wr_addr_q.size();
        dbase = done_q.size();
        tick();
        x0 = 9'd10; y0 = 8'd2; w = 9'd3; h = 8'd2; color = 16'hF800;
        start = 1'b1;
        k = int'($urandom_range(0, 15));
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'(5000 + k);
        expd = pre[k];
        t0 = cyc;
        tick();
        start = 1'b0;
        fin = 1'b0; to = 0; acks = 0;
        while (!fin && to < 100) begin
            if (cpu_ack) begin
                acks++;
                checks++;
                if (cpu_rdata !== expd) begin
                    errors++;
                    $display("FAIL contention_read[%0d]: got %h expected %h", acks, cpu_rdata, expd);
                end
                if (done_q.size() > dbase) begin
                    cpu_req = 1'b0;
                    fin = 1'b1;
                end else begin
                    k = int'($urandom_range(0, 15));
                    cpu_addr = 17'(5000 + k);
                    expd = pre[k];
                end
            end
            if (!fin) tick();
            to++;
        end
        checks++;
        if (!fin || acks !== 7) begin
            errors++;
            $display("FAIL contention_acks: got %0d acks (finished %b) expected 7 (finished 1)", acks, fin);
        end
        n = wr_addr_q.size() - base;
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL contention_count: got %0d fill writes expected 6", n);
        end
        for (int i = 0; i < n && i < 6; i++) begin
            checks++;
            if (wr_addr_q[base+i] !== exp_q[i] || wr_cyc_q[base+i] !== t0 + 1 + 2 * i) begin
                errors++;
                $display("FAIL contention_pixel[%0d]: got addr %0d cyc %0d expected addr %0d cyc %0d",
                         i, wr_addr_q[base+i], wr_cyc_q[base+i] - t0, exp_q[i], 1 + 2 * i);
            end
        end
        tick();
    endtask

    task automatic test_spill();
        int want;
`ifdef FILL_CLIP_EN
        want = 2;
`else
        want = 20;
`endif
        run_fill(318, 239, 5, 4, 16'hABCD, 1'b0);
        checks++;
        if (exp_q.size() !== want || exp_q[0] !== 76798) begin
            errors++;
            $display("FAIL spill_model: got %0d pixels expected %0d from 76798", exp_q.size(), want);
        end
    endtask

    task automatic test_reset_mid();
        int base, dbase, to, nw;
        base  = wr_addr_q.size();
        dbase = done_q.size();
        x0 = 9'd10; y0 = 8'd2; w = 9'd3; h = 8'd2; color = 16'h07E0;
        start = 1'b1;
        tick();
        start = 1'b0;
        to = 0;
        while (wr_addr_q.size() - base < 3 && to < 50) begin
            tick();
            to++;
        end
        reset = 1'b1;
        tick();
        nw = wr_addr_q.size() - base;
        checks++;
        if (busy !== 1'b0 || vram_we !== 1'b0 || nw > 4 || nw < 3) begin
            errors++;
            $display("FAIL reset_mid_stop: got busy %b we %b writes %0d expected busy 0 we 0 writes 3..4",
                     busy, vram_we, nw);
        end
        reset = 1'b0;
        repeat (10) tick();
        checks++;
        if (wr_addr_q.size() - base !== nw || done_q.size() !== dbase) begin
            errors++;
            $display("FAIL reset_mid_quiet: got writes %0d dones %0d expected writes %0d dones 0",
                     wr_addr_q.size() - base, done_q.size() - dbase, nw);
        end
        // Reset during a granted cycle drops the ack; the held request is then re-served
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'd100;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (cpu_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack_drop: got ack %b expected 0", cpu_ack);
        end
        tick();
        checks++;
        if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL reset_ack_reissue: got ack %b data %h expected ack 1 data 1234", cpu_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic test_random_fills();
        for (int i = 0; i < 6; i++) begin
            run_fill(int'($urandom_range(0, 330)), int'($urandom_range(0, 250)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
                     16'($urandom), 1'($urandom_range(0, 1)));
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        test_reset();
        test_basic_fill();
        test_zero_size();
        test_cpu_rw();
        test_contention();
        test_spill();
        test_reset_mid();
        test_random_fills();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
